// File: rtl/inst_fetcher.sv
// Instruction-fetch controller: cache lookup, byte-wide refill on miss, redirect flush.
// Optional FETCHER_STATS_EN adds stat_hits / stat_misses counters.
//
// state | meaning
// FETCH | look up pc in the cache, push hits into the queue
// FILL  | collect 4 refill bytes, then write the word into the cache
// DRAIN | redirected mid-refill; finish the outstanding word and discard it
module inst_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ic_addr,
  input  logic        ic_hit,
  input  logic [31:0] ic_inst,
  output logic        ic_wr_en,
  output logic [31:0] ic_wr_addr,
  output logic [31:0] ic_wr_inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_byte_valid,
  input  logic [7:0]  mem_byte,
  input  logic        iq_full,
  output logic        iq_valid,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc
`ifdef FETCHER_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`endif
);

  typedef enum logic [1:0] {FETCH, FILL, DRAIN} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [1:0]  byte_cnt;
  logic [31:0] fill_buf;
  logic        fill_done;
  logic        iq_valid_r;
  logic        wr_en_r;
  logic        byp_hit;
  logic        eff_hit;
  logic [31:0] eff_inst;
  logic        last_byte;

  assign ic_addr  = pc;
  // Pulses are masked while stalled so a held register is presented exactly once.
  assign iq_valid = iq_valid_r & rdy;
  assign ic_wr_en = wr_en_r & rdy;

  // The refilled word is forwarded during its write cycle so the retry never depends
  // on the cache reflecting a same-cycle write.
  assign byp_hit   = wr_en_r && (ic_wr_addr == pc);
  assign eff_hit   = ic_hit || byp_hit;
  assign eff_inst  = ic_hit ? ic_inst : ic_wr_inst;
  assign last_byte = mem_byte_valid && (byte_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      byte_cnt    <= 2'd0;
      fill_buf    <= 32'h0;
      fill_done   <= 1'b0;
      iq_valid_r  <= 1'b0;
      iq_inst     <= 32'h0;
      iq_pc       <= 32'h0;
      wr_en_r     <= 1'b0;
      ic_wr_addr  <= 32'h0;
      ic_wr_inst  <= 32'h0;
      mem_req     <= 1'b0;
      mem_addr    <= 32'h0;
`ifdef FETCHER_STATS_EN
      stat_hits   <= 32'h0;
      stat_misses <= 32'h0;
`endif
    end else if (rdy) begin
      iq_valid_r <= 1'b0;
      wr_en_r    <= 1'b0;
      case (state)
        FETCH: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
          end else if (eff_hit) begin
            if (!iq_full) begin
              iq_valid_r <= 1'b1;
              iq_inst    <= eff_inst;
              iq_pc      <= pc;
              pc         <= pc + 32'd4;
`ifdef FETCHER_STATS_EN
              stat_hits  <= stat_hits + 32'd1;
`endif
            end
          end else begin
            state       <= FILL;
            byte_cnt    <= 2'd0;
            fill_done   <= 1'b0;
            mem_req     <= 1'b1;
            mem_addr    <= {pc[31:2], 2'b00};
`ifdef FETCHER_STATS_EN
            stat_misses <= stat_misses + 32'd1;
`endif
          end
        end
        FILL: begin
          if (fill_done) begin
            state <= FETCH;
            if (redirect_valid) begin
              pc <= redirect_pc;
            end else begin
              wr_en_r    <= 1'b1;
              ic_wr_addr <= pc;
              ic_wr_inst <= fill_buf;
            end
          end else begin
            if (mem_byte_valid) begin
              fill_buf[8*byte_cnt +: 8] <= mem_byte;
              byte_cnt                  <= byte_cnt + 2'd1;
            end
            if (last_byte) begin
              mem_req <= 1'b0;
              if (redirect_valid) state <= FETCH;
              else fill_done <= 1'b1;
            end else if (redirect_valid) begin
              state <= DRAIN;
            end
            if (redirect_valid) pc <= redirect_pc;
          end
        end
        DRAIN: begin
          if (redirect_valid) pc <= redirect_pc;
          if (mem_byte_valid) byte_cnt <= byte_cnt + 2'd1;
          if (last_byte) begin
            mem_req <= 1'b0;
            state   <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed self-checking bench for inst_fetcher: hits, refill, stall, drain, rdy hold.
// Define FETCHER_STATS_EN to also check the hit/miss counters.
module tb_inst_fetcher;

  logic        clk = 1'b0;
  logic        rst, rdy, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] ic_addr;
  logic        ic_hit;
  logic [31:0] ic_inst;
  logic        ic_wr_en;
  logic [31:0] ic_wr_addr, ic_wr_inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_byte_valid;
  logic [7:0]  mem_byte;
  logic        iq_full;
  logic        iq_valid;
  logic [31:0] iq_inst, iq_pc;
`ifdef FETCHER_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  inst_fetcher #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ic_addr(ic_addr), .ic_hit(ic_hit), .ic_inst(ic_inst),
    .ic_wr_en(ic_wr_en), .ic_wr_addr(ic_wr_addr), .ic_wr_inst(ic_wr_inst),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_byte_valid(mem_byte_valid), .mem_byte(mem_byte),
    .iq_full(iq_full), .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc)
`ifdef FETCHER_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  // Cache model: fixed preloaded ranges plus words written by the DUT.
  function automatic logic pre_hit(input logic [31:0] a);
    return (a < 32'hC) || (a >= 32'h104 && a < 32'h180) || (a >= 32'h200 && a < 32'h280);
  endfunction

  function automatic logic [31:0] pre_data(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  logic [31:0] wt_addr [8];
  logic [31:0] wt_data [8];
  logic        wt_val  [8];
  int          wt_n = 0;

  initial for (int i = 0; i < 8; i++) wt_val[i] = 1'b0;

  always @(posedge clk) begin
    if (ic_wr_en && wt_n < 8) begin
      wt_addr[wt_n] <= ic_wr_addr;
      wt_data[wt_n] <= ic_wr_inst;
      wt_val[wt_n]  <= 1'b1;
      wt_n          <= wt_n + 1;
    end
  end

  always_comb begin
    ic_hit  = 1'b0;
    ic_inst = 32'h0;
    if (pre_hit(ic_addr)) begin
      ic_hit  = 1'b1;
      ic_inst = pre_data(ic_addr);
    end
    for (int i = 0; i < 8; i++) begin
      if (wt_val[i] && wt_addr[i] == ic_addr) begin
        ic_hit  = 1'b1;
        ic_inst = wt_data[i];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic byte_in(input logic v, input logic [7:0] b);
    mem_byte_valid = v;
    mem_byte       = b;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    iq_full = 1'b0; mem_byte_valid = 1'b0; mem_byte = 8'h0;
    tick(); tick();
    check("rst_iq_valid", {31'b0, iq_valid}, 32'h0);
    check("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("rst_wr_en", {31'b0, ic_wr_en}, 32'h0);
    check("rst_ic_addr", ic_addr, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    rst = 1'b0;

    // Three back-to-back hits from reset.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hit_valid", {31'b0, iq_valid}, 32'h1);
      check("hit_pc", iq_pc, 32'(4 * i));
      check("hit_inst", iq_inst, pre_data(32'(4 * i)));
    end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("redir_no_push", {31'b0, iq_valid}, 32'h0);
    check("redir_ic_addr", ic_addr, 32'h100);

    // Miss at 0x100.
    tick();
    check("miss_req", {31'b0, mem_req}, 32'h1);
    check("miss_addr", mem_addr, 32'h100);
    byte_in(1, 8'h13); tick();
    byte_in(1, 8'h05); tick();
    byte_in(1, 8'hA0); tick();
    byte_in(1, 8'h00); tick();
    byte_in(0, 8'h00);
    check("fill_req_drop", {31'b0, mem_req}, 32'h0);
    check("fill_no_wr_yet", {31'b0, ic_wr_en}, 32'h0);
    tick();
    check("fill_wr_en", {31'b0, ic_wr_en}, 32'h1);
    check("fill_wr_addr", ic_wr_addr, 32'h100);
    check("fill_wr_inst", ic_wr_inst, 32'h00A00513);
    tick();
    check("retry_valid", {31'b0, iq_valid}, 32'h1);
    check("retry_inst", iq_inst, 32'h00A00513);
    check("retry_pc", iq_pc, 32'h100);
    check("retry_wr_clear", {31'b0, ic_wr_en}, 32'h0);
`ifdef FETCHER_STATS_EN
    check("stat_hits", stat_hits, 32'd4);
    check("stat_misses", stat_misses, 32'd1);
`endif

    // Queue full for three cycles.
    iq_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_no_push", {31'b0, iq_valid}, 32'h0);
      check("full_pc_hold", ic_addr, 32'h104);
    end
    iq_full = 1'b0;
    tick();
    check("full_resume_valid", {31'b0, iq_valid}, 32'h1);
    check("full_resume_pc", iq_pc, 32'h104);

    // Redirect into a miss, then redirect again after two refill bytes.
    redirect_valid = 1'b1; redirect_pc = 32'h180;
    tick();
    redirect_valid = 1'b0;
    check("redir2_no_push", {31'b0, iq_valid}, 32'h0);
    check("redir2_ic_addr", ic_addr, 32'h180);
    tick();
    check("drain_req", {31'b0, mem_req}, 32'h1);
    check("drain_addr", mem_addr, 32'h180);
    byte_in(1, 8'h11); tick();
    byte_in(1, 8'h22); redirect_valid = 1'b1; redirect_pc = 32'h200; tick();
    redirect_valid = 1'b0;
    check("drain_req_b3", {31'b0, mem_req}, 32'h1);
    check("drain_ic_addr", ic_addr, 32'h200);
    byte_in(1, 8'h33); tick();
    check("drain_req_b4", {31'b0, mem_req}, 32'h1);
    byte_in(1, 8'h44); tick();
    byte_in(0, 8'h00);
    check("drain_req_drop", {31'b0, mem_req}, 32'h0);
    check("drain_no_wr", {31'b0, ic_wr_en}, 32'h0);
    tick();
    check("drain_push_valid", {31'b0, iq_valid}, 32'h1);
    check("drain_push_pc", iq_pc, 32'h200);
    check("drain_push_inst", iq_inst, pre_data(32'h200));
    check("drain_no_wr2", {31'b0, ic_wr_en}, 32'h0);

    // rdy low for five cycles mid-refill.
    redirect_valid = 1'b1; redirect_pc = 32'h184;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("rdy_req", {31'b0, mem_req}, 32'h1);
    check("rdy_addr", mem_addr, 32'h184);
    byte_in(1, 8'hEF); tick();
    byte_in(1, 8'hBE); tick();
    byte_in(0, 8'h00); rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rdy_hold_pc", ic_addr, 32'h184);
      check("rdy_hold_req", {31'b0, mem_req}, 32'h1);
      check("rdy_no_wr", {31'b0, ic_wr_en}, 32'h0);
      check("rdy_no_push", {31'b0, iq_valid}, 32'h0);
    end
    rdy = 1'b1;
    byte_in(1, 8'hAD); tick();
    byte_in(1, 8'hDE); tick();
    byte_in(0, 8'h00);
    check("rdy_req_drop", {31'b0, mem_req}, 32'h0);
    tick();
    check("rdy_wr_en", {31'b0, ic_wr_en}, 32'h1);
    check("rdy_wr_inst", ic_wr_inst, 32'hDEADBEEF);
    check("rdy_wr_addr", ic_wr_addr, 32'h184);
    tick();
    check("rdy_push_inst", iq_inst, 32'hDEADBEEF);
    check("rdy_push_pc", iq_pc, 32'h184);

    // Next pc 0x188 misses; redirect lands on the 4th byte, word is dropped.
    tick();
    check("late_req", {31'b0, mem_req}, 32'h1);
    check("late_addr", mem_addr, 32'h188);
    byte_in(1, 8'h01); tick();
    byte_in(1, 8'h02); tick();
    byte_in(1, 8'h03); tick();
    byte_in(1, 8'h04); redirect_valid = 1'b1; redirect_pc = 32'h204; tick();
    byte_in(0, 8'h00); redirect_valid = 1'b0;
    check("late_req_drop", {31'b0, mem_req}, 32'h0);
    check("late_ic_addr", ic_addr, 32'h204);
    check("late_no_wr", {31'b0, ic_wr_en}, 32'h0);
    tick();
    check("late_no_wr2", {31'b0, ic_wr_en}, 32'h0);
    check("late_push_valid", {31'b0, iq_valid}, 32'h1);
    check("late_push_pc", iq_pc, 32'h204);

    // A push pending while rdy is low is presented once rdy returns.
    tick();
    rdy = 1'b0;
    #1;
    check("mask_push", {31'b0, iq_valid}, 32'h0);
    tick();
    rdy = 1'b1;
    #1;
    check("unmask_push", {31'b0, iq_valid}, 32'h1);
    check("unmask_pc", iq_pc, 32'h208);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetcher.md
# inst_fetcher

Instruction-fetch controller that sequences the instruction cache and the byte-wide memory port. Each cycle it looks up the current PC in the cache, pushes hits into the instruction queue, and on a miss runs a 4-byte refill through the memory arbiter, writes the word into the cache, then retries. Branch/exception redirects flush it at any point. It sits between the PC/redirect logic, the instruction cache, the memory arbiter and the instruction queue.

## Interface

- RESET_PC, 32'h0: PC loaded on reset.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; when low, all state holds and no outputs change.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch PC.
- ic_addr  out  32  cache lookup address; combinational, equals pc.
- ic_hit  in  1  cache hit for ic_addr, same cycle.
- ic_inst  in  32  cached word, valid when ic_hit.
- ic_wr_en  out  1  one-cycle cache write strobe.
- ic_wr_addr  out  32  write address.
- ic_wr_inst  out  32  write data.
- mem_req  out  1  word-fetch request to the arbiter.
- mem_addr  out  32  word address; bits [1:0] are always 0.
- mem_byte_valid  in  1  one returned byte this cycle.
- mem_byte  in  8  returned byte, little-endian order.
- iq_full  in  1  queue cannot accept an instruction this cycle.
- iq_valid  out  1  push strobe.
- iq_inst  out  32  instruction.
- iq_pc  out  32  PC of iq_inst.

## Operation

- Registers: pc, state {FETCH, FILL, DRAIN}, byte_cnt[1:0], buf[31:0].
- Reset values: pc=RESET_PC, state=FETCH, byte_cnt=0, buf=0, and every output 0 except ic_addr (equals pc).
- FETCH:
  - When ic_hit && !iq_full: register iq_valid=1, iq_inst=ic_inst, iq_pc=pc; then pc+=4, wrapping mod 2^32.
  - When ic_hit && iq_full: stall with no push.
  - When !ic_hit: go to FILL, clear byte_cnt, and register mem_req=1, mem_addr={pc[31:2],2'b00}.
- FILL:
  - mem_req stays high. Each mem_byte_valid writes mem_byte into buf[8*byte_cnt+:8] and increments byte_cnt.
  - On the 4th byte: drop mem_req. Next cycle, pulse ic_wr_en with ic_wr_addr=pc and ic_wr_inst equal to the assembled word. Return to FETCH; the following lookup hits.
  - Nothing is pushed to the queue directly from FILL.
- DRAIN: entered when a redirect arrives during FILL.
  - mem_req stays high until the outstanding word completes, because the arbiter cannot abort a word.
  - Bytes are counted and discarded; there is no cache write.
  - After the 4th byte, drop mem_req and go to FETCH.
- Redirect:
  - Highest priority in every state. pc<=redirect_pc and iq_valid=0 next cycle; a same-cycle hit is not pushed.
  - FETCH goes to FETCH; FILL goes to DRAIN; DRAIN stays in DRAIN.
- iq_valid and ic_wr_en are single-cycle pulses, cleared the cycle after they are asserted.
- rdy low: every register holds. iq_valid and ic_wr_en are forced 0. Incoming byte strobes are not expected while rdy is low.

## Timing

- Hit: lookup in cycle N, push visible in N+1, one instruction per cycle sustained.
- Miss: request registered at edge N+1. With arbiter/memory latency L to the first byte and one byte per cycle after that, the write strobe is at N+L+5 and the push at N+L+6.
- Redirect in cycle N: ic_addr=redirect_pc in N+1; a hit there pushes in N+2.
- Redirect on the same edge as the 4th FILL byte: the word is dropped (no cache write) and the block goes to FETCH at redirect_pc.

## Configuration

- FETCHER_STATS_EN:
  - Defined: adds outputs stat_hits[31:0] and stat_misses[31:0], both reset to 0 and wrapping.
  - stat_hits increments on each push. stat_misses increments on each FETCH→FILL transition.
  - Both hold when rdy is low.
  - Undefined: these ports and counters do not exist; fetch behaviour is identical.

## Test plan

- Reset with RESET_PC=0 and the cache pre-filled at 0x0/0x4/0x8 → three consecutive pushes (iq_pc 0,4,8) in cycles 1-3 after reset release.
- Miss at 0x100, bytes 0x13,0x05,0xA0,0x00 → ic_wr_inst=0x00A00513 at 0x100, then a push of that word with iq_pc=0x100.
- iq_full held for 3 cycles while hitting → no push, pc frozen; push resumes the cycle after iq_full falls.
- Redirect to 0x200 after 2 FILL bytes → mem_req stays high for the remaining 2 bytes, no ic_wr_en, then lookup at 0x200.
- rdy low for 5 cycles mid-FILL → byte_cnt and pc unchanged, no strobes; completion after rdy returns high.
- FETCHER_STATS_EN defined, 3 hits plus 1 miss-then-hit → stat_hits=4, stat_misses=1.
